pi_error_sequencer_water1: RTL and testbench
============================================

Name: pi_error_sequencer_water1

Overview:
- Upstream stage of the water-loop PI limiter; forms the control error `x = ref - meas` (IEEE-754 single) once per simulation time step.
- Drives the PI's `x`, `done_read_x` and `sta`, with `done_read_x` leading `sta` by exactly `LEAD_CLK` cycles.
- Waits for the PI's `done_sig`, then reports step completion. Flags overruns when a new step arrives while busy.

Parameters:
- ADD_LAT, 7: pipeline latency in cycles of the Adder_nodsp instance used for the subtraction.
- LEAD_CLK, 15: cycles from the `done_read_x` pulse to the `sta` pulse.
- PI_TIMEOUT, 63: maximum cycles to wait for `pi_done` after `sta`.
- DEADBAND, 32'h3A83126F: error magnitude threshold (1e-3). Used only with ERR_DEADBAND_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- step  in  1  one-cycle time-step strobe
- ref  in  `SINGLE  setpoint, sampled on step
- meas  in  `SINGLE  measurement, sampled on step
- pi_done  in  1  done_sig returned by the PI limiter
- x  out  `SINGLE  error to the PI; held stable from done_read_x until the next accepted step
- done_read_x  out  1  one-cycle pulse, x valid
- sta  out  1  one-cycle start pulse to the PI
- busy  out  1  high from the accepted step until the DONE state exits
- done_sig  out  1  one-cycle pulse, step complete
- overrun  out  1  sticky: step arrived while busy
- timeout  out  1  sticky: pi_done not seen within PI_TIMEOUT

Behaviour:
- Reset (async, rst=1): all outputs 0, x=32'h0, FSM=IDLE, counters 0. A reset mid-operation aborts the step immediately; no pulses follow reset release.
- IDLE, step=1: latch ref/meas into the operand registers, go to SUB, busy=1 from the next cycle.
- SUB: Adder_nodsp in subtract mode, dataa=ref_reg, datab=meas_reg, clk_en=`ena_math, aclr=rst. The counter runs 0..ADD_LAT-1.
  - On the final count, register the result into x and pulse done_read_x.
  - The pulse occurs ADD_LAT+1 cycles after step, counting the step cycle as cycle 0.
- LEAD: count LEAD_CLK-1 cycles, then pulse sta. The sta pulse comes exactly LEAD_CLK cycles after done_read_x, then go to WAIT.
- WAIT: count cycles since sta.
  - pi_done=1: go to DONE.
  - Count reaches PI_TIMEOUT: set timeout, go to DONE.
  - pi_done arriving in the same cycle as the timeout: treated as done, timeout not set.
- DONE: pulse done_sig for one cycle, busy=0 on the next cycle, return to IDLE.
- A step accepted in the same cycle as the DONE→IDLE transition is ignored and sets overrun. A step is accepted only in IDLE.
- step while busy: ignored, overrun=1 (sticky until rst). Latched operands and x are unaffected.
- pi_done outside WAIT: ignored.
- x is not cleared between steps; it changes only at done_read_x.
- Arithmetic is IEEE-754 single via the adder IP; the block does no special NaN/Inf handling and passes results through.

Optional Feature:
- Macro: ERR_DEADBAND_EN.
- Defined:
  - On the cycle the adder result is captured, compare `result[30:0]` against `DEADBAND[30:0]` as unsigned integers (magnitude compare for non-NaN values).
  - If less, x=32'h00000000 (+0.0); otherwise x=result.
  - No added latency.
- Undefined: x=result always; DEADBAND is unused.

Test Plan:
- Nominal step:
  - Stimulus: rst low, ref=3F800000 (1.0), meas=3F000000 (0.5), step pulse at cycle 0, pi_done returned 30 cycles after sta.
  - Required response: x=3F000000, done_read_x at cycle ADD_LAT+1=8, sta at cycle 23, done_sig one cycle after pi_done, busy low the following cycle.
- Negative error:
  - Stimulus: ref=0, meas=3FC00000 (1.5).
  - Required response: x=BFC00000, timing identical to the nominal step.
- Overrun:
  - Stimulus: second step at cycle 12 of a running step with different operands.
  - Required response: overrun=1 and stays 1, x of the first step unchanged, only one done_read_x/sta pair.
- Timeout:
  - Stimulus: pi_done never asserted.
  - Required response: timeout=1 at sta+63, done_sig pulses, FSM returns to IDLE and accepts the next step normally.
- Reset mid-operation:
  - Stimulus: rst asserted during LEAD.
  - Required response: all outputs 0 immediately (async), no sta after rst release, the next step runs the nominal timing.
- Deadband (with ERR_DEADBAND_EN):
  - ref=3F800000, meas=3F7FF972 (difference ≈1e-4) → x=00000000.
  - ref=3F800000, meas=3F7EF9DB (difference ≈4e-3) → x=3B83126F approximately (nonzero).

Source files
------------

// File: rtl/pi_error_sequencer_water1.sv
// Error former ahead of the water-loop PI limiter: x = ref - meas, then done_read_x / sta / done_sig sequencing.
// Optional macro ERR_DEADBAND_EN forces x to +0.0 when |ref - meas| < DEADBAND. `ref` is reserved in SV, so the setpoint port is ref_in.

`ifndef SINGLE
`define SINGLE [31:0]
`endif
`ifndef ENA_MATH
`define ENA_MATH 1'b1
`endif

module Adder_nodsp #(
    parameter int LAT = 7
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         clk_en,
    input  logic         add_sub,
    input  logic [31:0]  dataa,
    input  logic [31:0]  datab,
    output logic [31:0]  result
);
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  ex, ey, d;
        logic [27:0] mx, my, sh, sum;
        logic [9:0]  e;
        logic        sticky, rnd;
        logic [24:0] man;
        if (&a[30:23] || &b[30:23]) begin
            if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]) ||
                (&a[30:23] && &b[30:23] && (a[31] != b[31])))
                return 32'h7FC00000;
            return (&a[30:23]) ? a : b;
        end
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {1'b0, |x[30:23], x[22:0], 3'b000};
        my = {1'b0, |y[30:23], y[22:0], 3'b000};
        d  = ex - ey;
        if (d >= 8'd27) begin
            sh     = '0;
            sticky = |my;
        end else begin
            sh     = my >> d;
            sticky = ((sh << d) != my);
        end
        sh[0] = sh[0] | sticky;
        sum = (x[31] == y[31]) ? (mx + sh) : (mx - sh);
        e   = {2'b00, ex};
        if (sum == '0)
            return 32'h00000000;
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
        end else begin
            // normalise left, stopping at the denormal exponent
            for (int unsigned i = 0; i < 26; i++) begin
                if (!sum[26] && (e > 10'd1)) begin
                    sum = sum << 1;
                    e   = e - 10'd1;
                end
            end
        end
        rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
        man = {1'b0, sum[26:3]} + {24'd0, rnd};
        if (man[24]) begin
            man = man >> 1;
            e   = e + 10'd1;
        end
        if (e >= 10'd255)
            return {x[31], 8'hFF, 23'd0};
        return {x[31], (man[23] ? e[7:0] : 8'h00), man[22:0]};
    endfunction

    logic [31:0] sum_d;

    always_comb begin
        sum_d = fp_add(dataa, add_sub ? datab : {~datab[31], datab[30:0]});
    end

    // The consumer's capture register acts as the final stage, so only LAT-1 stages live here.
    if (LAT > 1) begin : g_pipe
        logic [31:0] pipe_q [LAT-1];

        always_ff @(posedge clk or posedge aclr) begin
            if (aclr)
                pipe_q[0] <= '0;
            else if (clk_en)
                pipe_q[0] <= sum_d;
        end

        for (genvar g = 1; g < LAT - 1; g++) begin : g_stage
            always_ff @(posedge clk or posedge aclr) begin
                if (aclr)
                    pipe_q[g] <= '0;
                else if (clk_en)
                    pipe_q[g] <= pipe_q[g-1];
            end
        end

        assign result = pipe_q[LAT-2];
    end else begin : g_comb
        assign result = sum_d;
    end
endmodule

module pi_error_sequencer_water1 #(
    parameter int          ADD_LAT    = 7,
    parameter int          LEAD_CLK   = 15,
    parameter int          PI_TIMEOUT = 63,
    parameter logic [31:0] DEADBAND   = 32'h3A83126F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic `SINGLE  ref_in,
    input  logic `SINGLE  meas,
    input  logic          pi_done,
    output logic `SINGLE  x,
    output logic          done_read_x,
    output logic          sta,
    output logic          busy,
    output logic          done_sig,
    output logic          overrun,
    output logic          timeout
);
    localparam int CNT_W = $clog2(ADD_LAT + LEAD_CLK + PI_TIMEOUT + 1);
`ifdef ERR_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SUB,
        LEAD,
        WAIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        ref_q, ref_d;
    logic [31:0]        meas_q, meas_d;
    logic [31:0]        x_q, x_d;
    logic               drx_q, drx_d;
    logic               sta_q, sta_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic [31:0]        sub_res;
    logic               in_deadband;

    Adder_nodsp #(
        .LAT (ADD_LAT)
    ) u_sub (
        .clk     (clk),
        .aclr    (rst),
        .clk_en  (`ENA_MATH),
        .add_sub (1'b0),
        .dataa   (ref_q),
        .datab   (meas_q),
        .result  (sub_res)
    );

    always_comb begin
        in_deadband = (sub_res[30:0] < DEADBAND[30:0]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        meas_d    = meas_q;
        x_d       = x_q;
        drx_d     = 1'b0;
        sta_d     = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        if (step && (state_q != IDLE))
            overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (step) begin
                    ref_d   = ref_in;
                    meas_d  = meas;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (cnt_q == CNT_W'(ADD_LAT - 1)) begin
                    x_d     = (DB_EN && in_deadband) ? 32'h00000000 : sub_res;
                    drx_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = LEAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LEAD: begin
                if (cnt_q == CNT_W'(LEAD_CLK - 1)) begin
                    sta_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                // pi_done wins over a coincident timeout
                if (pi_done) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(PI_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ref_q     <= '0;
            meas_q    <= '0;
            x_q       <= '0;
            drx_q     <= 1'b0;
            sta_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            meas_q    <= meas_d;
            x_q       <= x_d;
            drx_q     <= drx_d;
            sta_q     <= sta_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign x           = x_q;
    assign done_read_x = drx_q;
    assign sta         = sta_q;
    assign busy        = busy_q;
    assign done_sig    = done_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_pi_error_sequencer_water1.sv
// Directed bench for pi_error_sequencer_water1; cycle 0 is the cycle in which step is high.
// Define ERR_DEADBAND_EN for both files to exercise the deadband cases.

module tb_pi_error_sequencer_water1;
    logic        clk = 1'b0;
    logic        rst, step, pi_done;
    logic [31:0] ref_in, meas;
    logic [31:0] x;
    logic        done_read_x, sta, busy, done_sig, overrun, timeout;

    int passed = 0;
    int total  = 0;

    int t_drx, n_drx, t_sta, n_sta, t_done, n_done, t_nbusy, t_ovr, t_to;
    logic [31:0] x_drx, x_end;
    bit busy_c1, rst_zero;

    pi_error_sequencer_water1 #(
        .ADD_LAT    (7),
        .LEAD_CLK   (15),
        .PI_TIMEOUT (63),
        .DEADBAND   (32'h3A83126F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .ref_in      (ref_in),
        .meas        (meas),
        .pi_done     (pi_done),
        .x           (x),
        .done_read_x (done_read_x),
        .sta         (sta),
        .busy        (busy),
        .done_sig    (done_sig),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; step = 1'b0; pi_done = 1'b0; ref_in = '0; meas = '0;
        #2;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives one step at cycle 0 and records event cycles; inj_c / rst_c < 0 disable those events.
    task automatic run(input logic [31:0] r, input logic [31:0] m, input logic [31:0] r2,
                       input logic [31:0] m2, input int pi_rel, input int inj_c,
                       input int rst_c, input bit spur, input int ncyc);
        t_drx = -1; n_drx = 0; t_sta = -1; n_sta = 0; t_done = -1; n_done = 0;
        t_nbusy = -1; t_ovr = -1; t_to = -1; x_drx = 'x; busy_c1 = 1'b0; rst_zero = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (!rst) begin
                if (done_read_x) begin n_drx++; t_drx = c; x_drx = x; end
                if (sta) begin n_sta++; t_sta = c; end
                if (done_sig) begin n_done++; t_done = c; end
                if (c == 1) busy_c1 = busy;
                if (c > 1 && !busy && t_nbusy < 0 && n_done > 0) t_nbusy = c;
                if (overrun && t_ovr < 0) t_ovr = c;
                if (timeout && t_to < 0) t_to = c;
            end
            if (c == rst_c) begin
                rst = 1'b1;
                #1;
                rst_zero = (x === 32'h0) && !done_read_x && !sta && !busy &&
                           !done_sig && !overrun && !timeout;
            end
            if (rst_c >= 0 && c == rst_c + 2) rst = 1'b0;
            step    = (c == 0) || (c == inj_c);
            ref_in  = (c == inj_c) ? r2 : r;
            meas    = (c == inj_c) ? m2 : m;
            pi_done = (spur && c == 10) || (t_sta >= 0 && pi_rel >= 0 && c == t_sta + pi_rel);
            tick();
        end
        step = 1'b0; pi_done = 1'b0;
        x_end = x;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (x !== 32'h0) $display("FAIL reset_x: got %h want 00000000", x); else passed++;
        total++; if ({done_read_x, sta, done_sig} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {done_read_x, sta, done_sig}); else passed++;
        total++; if ({busy, overrun, timeout} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, overrun, timeout}); else passed++;
    endtask

    task automatic test_nominal();
        run(32'h3F800000, 32'h3F000000, 0, 0, 30, -1, -1, 1'b0, 70);
        total++; if (busy_c1 !== 1'b1) $display("FAIL nom_busy_c1: got %b want 1", busy_c1); else passed++;
        total++; if (x_drx !== 32'h3F000000) $display("FAIL nom_x: got %h want 3F000000", x_drx); else passed++;
        total++; if (t_drx != 8) $display("FAIL nom_drx_cycle: got %0d want 8", t_drx); else passed++;
        total++; if (t_sta != 23) $display("FAIL nom_sta_cycle: got %0d want 23", t_sta); else passed++;
        total++; if (t_done != 54) $display("FAIL nom_done_cycle: got %0d want 54", t_done); else passed++;
        total++; if (t_nbusy != 55) $display("FAIL nom_busy_low: got %0d want 55", t_nbusy); else passed++;
        total++; if (n_drx != 1 || n_sta != 1 || n_done != 1) $display("FAIL nom_counts: got %0d/%0d/%0d want 1/1/1", n_drx, n_sta, n_done); else passed++;
        total++; if (t_to != -1) $display("FAIL nom_no_timeout: got %0d want -1", t_to); else passed++;
    endtask

    task automatic test_negative();
        // spurious pi_done at cycle 10 (LEAD) must be ignored
        run(32'h00000000, 32'h3FC00000, 0, 0, 30, -1, -1, 1'b1, 70);
        total++; if (x_drx !== 32'hBFC00000) $display("FAIL neg_x: got %h want BFC00000", x_drx); else passed++;
        total++; if (t_drx != 8 || t_sta != 23) $display("FAIL neg_timing: got drx %0d sta %0d want 8 23", t_drx, t_sta); else passed++;
        total++; if (t_done != 54 || n_done != 1) $display("FAIL neg_done: got %0d n %0d want 54 n 1", t_done, n_done); else passed++;
    endtask

    task automatic test_back_to_back();
        run(32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3F800000, 5, 30, -1, 1'b0, 70);
        total++; if (n_drx != 2 || n_done != 2) $display("FAIL b2b_counts: got drx %0d done %0d want 2 2", n_drx, n_done); else passed++;
        total++; if (t_drx != 38) $display("FAIL b2b_drx_cycle: got %0d want 38", t_drx); else passed++;
        total++; if (x_drx !== 32'h3F800000) $display("FAIL b2b_x: got %h want 3F800000", x_drx); else passed++;
        total++; if (t_ovr != -1) $display("FAIL b2b_no_overrun: got %0d want -1", t_ovr); else passed++;
    endtask

    task automatic test_done_boundary();
        apply_reset();
        run(32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3F800000, 5, 29, -1, 1'b0, 60);
        total++; if (t_done != 29) $display("FAIL dbnd_done_cycle: got %0d want 29", t_done); else passed++;
        total++; if (n_drx != 1) $display("FAIL dbnd_ignored: got %0d want 1", n_drx); else passed++;
        total++; if (t_ovr != 30) $display("FAIL dbnd_overrun: got %0d want 30", t_ovr); else passed++;
    endtask

    task automatic test_overrun();
        apply_reset();
        run(32'h3F800000, 32'h3F000000, 32'h40000000, 32'h00000000, 5, 12, -1, 1'b0, 60);
        total++; if (t_ovr != 13) $display("FAIL ovr_cycle: got %0d want 13", t_ovr); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
        total++; if (x_drx !== 32'h3F000000 || x_end !== 32'h3F000000) $display("FAIL ovr_x: got %h/%h want 3F000000", x_drx, x_end); else passed++;
        total++; if (n_drx != 1 || n_sta != 1) $display("FAIL ovr_pairs: got %0d/%0d want 1/1", n_drx, n_sta); else passed++;
    endtask

    task automatic test_timeout();
        apply_reset();
        run(32'h40400000, 32'h3F800000, 0, 0, -1, -1, -1, 1'b0, 100);
        total++; if (x_drx !== 32'h40000000) $display("FAIL to_x: got %h want 40000000", x_drx); else passed++;
        total++; if (t_to != 86) $display("FAIL to_cycle: got %0d want 86", t_to); else passed++;
        total++; if (t_done != 86 || n_done != 1) $display("FAIL to_done: got %0d n %0d want 86 n 1", t_done, n_done); else passed++;
        total++; if (t_nbusy != 87) $display("FAIL to_busy_low: got %0d want 87", t_nbusy); else passed++;
        run(32'h3F800000, 32'h3F000000, 0, 0, 30, -1, -1, 1'b0, 70);
        total++; if (t_drx != 8 || t_sta != 23 || t_done != 54) $display("FAIL to_next_step: got %0d/%0d/%0d want 8/23/54", t_drx, t_sta, t_done); else passed++;
        total++; if (timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout); else passed++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run(32'h3F800000, 32'h3F000000, 0, 0, 30, -1, 15, 1'b0, 60);
        total++; if (rst_zero !== 1'b1) $display("FAIL rstmid_async_zero: got %b want 1", rst_zero); else passed++;
        total++; if (n_sta != 0 || n_done != 0) $display("FAIL rstmid_no_pulses: got sta %0d done %0d want 0 0", n_sta, n_done); else passed++;
        run(32'h3F800000, 32'h3F000000, 0, 0, 30, -1, -1, 1'b0, 70);
        total++; if (t_drx != 8 || t_sta != 23 || x_drx !== 32'h3F000000) $display("FAIL rstmid_next: got %0d/%0d/%h want 8/23/3F000000", t_drx, t_sta, x_drx); else passed++;
    endtask

`ifdef ERR_DEADBAND_EN
    task automatic test_deadband();
        run(32'h3F800000, 32'h3F7FF972, 0, 0, 5, -1, -1, 1'b0, 40);
        total++; if (x_drx !== 32'h00000000) $display("FAIL db_small: got %h want 00000000", x_drx); else passed++;
        run(32'h3F800000, 32'h3F7EF9DB, 0, 0, 5, -1, -1, 1'b0, 40);
        total++; if (x_drx !== 32'h3B831280) $display("FAIL db_large: got %h want 3B831280", x_drx); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_negative();
        test_back_to_back();
        test_done_boundary();
        test_overrun();
        test_timeout();
        test_reset_mid();
`ifdef ERR_DEADBAND_EN
        test_deadband();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
